if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end for the RV64 core; replaces the direct combinational PC→RAM instruction path.
- Owns the architectural fetch PC and issues one outstanding request at a time on a valid/ready instruction-memory port.
- Holds the returned instruction for id_stage behind a valid/ready handshake.
- Applies branch/jump redirects from exe_stage, discarding any stale in-flight response, and counts delivered instructions for difftest instrCnt.

Parameters:
- PC_START, 64'h0000_0000_8000_0000, PC loaded on reset (matches `PC_START in defines.v).
- XLEN, 64, PC/address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- redirect_valid  in  1  exe_stage branch/jump taken this cycle.
- redirect_pc  in  XLEN  new fetch target. Bits [1:0] are forced to 0 internally.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address, equal to the current PC.
- imem_resp_valid  in  1  instruction data valid, one-cycle pulse.
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to id_stage.
- inst_ready  in  1  id_stage consumes instruction.
- inst_pc  out  XLEN  PC of the held instruction.
- inst  out  32  held instruction word.
- fetch_cnt  out  64  number of instructions accepted by id_stage.

Behaviour:
- Reset (synchronous, active-high; also aborts any operation in progress):
  - pc=PC_START, state=REQ, drop=0, inst=0, inst_pc=0, fetch_cnt=0.
  - imem_req_valid=0 and inst_valid=0 during the reset cycle.
  - A response arriving after reset is ignored, because state is REQ rather than WAIT.
- States: REQ, WAIT, HOLD (2-bit encoding in the package).
- Combinational outputs:
  - imem_req_valid = (state==REQ) && !redirect_valid && !reset.
  - imem_req_addr = pc.
  - inst_valid = (state==HOLD) && !redirect_valid.
- REQ state:
  - redirect_valid: pc<=redirect_pc, stay REQ. No handshake can occur because req_valid is gated off.
  - Otherwise, imem_req_valid && imem_req_ready: go to WAIT.
  - Otherwise stay REQ. Address is held stable while valid and not ready.
- WAIT state:
  - imem_resp_valid && (drop || redirect_valid):
    - Discard the data; drop<=0; go to REQ.
    - If redirect_valid: pc<=redirect_pc.
  - imem_resp_valid, with no drop and no redirect: inst<=imem_resp_data, inst_pc<=pc, go to HOLD.
  - redirect_valid without resp: pc<=redirect_pc, drop<=1, stay WAIT.
  - A second redirect while drop=1 only updates pc.
- HOLD state:
  - redirect_valid: pc<=redirect_pc, go to REQ. Held instruction is squashed and not counted.
  - inst_valid && inst_ready: pc<=pc+4, fetch_cnt<=fetch_cnt+1, go to REQ.
  - Otherwise stay HOLD; inst and inst_pc are held stable.
- Memory protocol:
  - Exactly one outstanding request.
  - A response is legal only in WAIT, at least 1 cycle after the request handshake.
  - imem_resp_valid outside WAIT is ignored.
- Arithmetic and width rules:
  - pc+4 wraps modulo 2^64, with no trap.
  - fetch_cnt wraps modulo 2^64.
- Latency: with a zero-wait memory (ready=1, response next cycle), request handshake is cycle N, response N+1, inst_valid at N+2. Sustained throughput is 1 instruction per 3 cycles.
- Simultaneous events:
  - Redirect has priority over every handshake in every state.
  - reset has priority over redirect.

Decomposition:
- Shared package / defines.v additions:
  - FETCH_STATE_BUS width and the REQ/WAIT/HOLD encodings.
  - Reuse `PC_START and `REG_BUS.
- No sub-module: the FSM, PC register and counter fit in one module of roughly 150 lines.
- Integration changes:
  - RAM_1W2R gains a small req/resp wrapper.
  - SimTop takes cmt_pc/cmt_inst from inst_pc/inst.
  - instrCnt is driven from fetch_cnt.

Test Plan:
1. Reset, then memory with ready=1 and next-cycle response of 32'h00000013 at every address → req_addr=0x80000000 in cycle 1 after reset drop; inst_valid at cycle 3 with inst_pc=0x80000000; with inst_ready=1, next req_addr=0x80000004; fetch_cnt=1.
2. imem_req_ready=0 for 4 cycles → req_valid held high and req_addr stable at 0x80000000; no state change; handshake on the 5th cycle → WAIT.
3. Redirect to 0x80000100 one cycle after the handshake, with the response arriving 2 cycles later → stale response dropped, inst_valid stays 0; next req_addr=0x80000100; delivered inst_pc=0x80000100.
4. HOLD with inst_ready=0 for 3 cycles → inst and inst_pc stable; then redirect_valid=1 with inst_ready=1 in the same cycle → inst_valid=0 that cycle; fetch_cnt unchanged; next req_addr=redirect_pc.
5. redirect_pc=0x80000203 → req_addr=0x80000200.
6. Reset asserted while in WAIT, followed by a late response → state REQ, pc=PC_START, response ignored, inst_valid=0, fetch_cnt=0.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and bus widths.
package if_fetch_unit_pkg;

   localparam int unsigned FETCH_STATE_BUS = 2;
   localparam int unsigned INST_BUS        = 32;

   typedef enum logic [FETCH_STATE_BUS-1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps one request outstanding
// on the imem port, and holds the returned instruction for id_stage.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int unsigned      XLEN     = 64,
   parameter logic [XLEN-1:0]  PC_START = 64'h0000_0000_8000_0000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 redirect_valid,
   input  logic [XLEN-1:0]      redirect_pc,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [XLEN-1:0]      imem_req_addr,
   input  logic                 imem_resp_valid,
   input  logic [INST_BUS-1:0]  imem_resp_data,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic [XLEN-1:0]      inst_pc,
   output logic [INST_BUS-1:0]  inst,
   output logic [63:0]          fetch_cnt
);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic            drop;
   logic [XLEN-1:0] redirect_target;

   assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

   // Redirect gates both handshakes so a branch always wins over the same-cycle transfer.
   assign imem_req_valid = (state == ST_REQ) && !redirect_valid && !reset;
   assign imem_req_addr  = pc;
   assign inst_valid     = (state == ST_HOLD) && !redirect_valid && !reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         pc        <= PC_START;
         state     <= ST_REQ;
         drop      <= 1'b0;
         inst      <= '0;
         inst_pc   <= '0;
         fetch_cnt <= '0;
      end else begin
         case (state)
            ST_REQ: begin
               if (redirect_valid) begin
                  pc <= redirect_target;
               end else if (imem_req_valid && imem_req_ready) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_resp_valid && (drop || redirect_valid)) begin
                  drop  <= 1'b0;
                  state <= ST_REQ;
                  if (redirect_valid) begin
                     pc <= redirect_target;
                  end
               end else if (imem_resp_valid) begin
                  inst    <= imem_resp_data;
                  inst_pc <= pc;
                  state   <= ST_HOLD;
               end else if (redirect_valid) begin
                  // Request already in flight: remember to discard its response.
                  pc   <= redirect_target;
                  drop <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (redirect_valid) begin
                  pc    <= redirect_target;
                  state <= ST_REQ;
               end else if (inst_valid && inst_ready) begin
                  pc        <= pc + XLEN'(4);
                  fetch_cnt <= fetch_cnt + 64'd1;
                  state     <= ST_REQ;
               end
            end
            default: begin
               state <= ST_REQ;
            end
         endcase
      end
   end

endmodule
